// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_XNOR = 4'h9;
    localparam logic [3:0] OP_NAND = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;

    localparam int FLG_ZERO   = 0;
    localparam int FLG_CARRY  = 1;
    localparam int FLG_MOVF   = 2;
    localparam int FLG_BORROW = 3;
    localparam int FLG_INV    = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_div_seq.sv
// Restoring unsigned divider: one quotient bit per cycle, WIDTH iterations after start.
module alu_div_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             run;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_p0;
    logic [WIDTH-1:0] quo_p0;
    logic [WIDTH-1:0] dvs_p0;
    logic [WIDTH:0]   shifted;
    logic             take;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    always_comb begin
        shifted  = {rem_p0, quo_p0[WIDTH-1]};
        take     = (shifted >= {1'b0, dvs_p0});
        rem_nx   = WIDTH'(take ? (shifted - {1'b0, dvs_p0}) : shifted);
        quo_nx   = {quo_p0[WIDTH-2:0], take};
        // Final quotient is presented combinationally on the last iteration.
        done     = run && (cnt == CW'(1));
        quotient = quo_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= CW'(WIDTH);
        end else if (run) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1))
                run <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            rem_p0 <= '0;
            quo_p0 <= dividend;
            dvs_p0 <= divisor;
        end else if (run) begin
            rem_p0 <= rem_nx;
            quo_p0 <= quo_nx;
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked ALU with registered result/flags and iterative divide.
// Build option: define ALU_SAT_EN for saturating ADD/SUB/MUL.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic             busy
);

`ifdef ALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] sat_hi(input logic [WIDTH-1:0] v, input logic ovf);
        return (SAT_EN && ovf) ? '1 : v;
    endfunction

    function automatic logic [WIDTH-1:0] sat_lo(input logic [WIDTH-1:0] v, input logic ovf);
        return (SAT_EN && ovf) ? '0 : v;
    endfunction

    state_t state, state_nx;
    logic               accept;
    logic               div_go;
    logic               div_done;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   res_p0;
    logic [4:0]         flg_p0;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] shl_full;
    logic [2*WIDTH-1:0] shr_full;
    logic               sh_big;

    assign out_valid = (state == S_OUT);
    assign busy      = (state == S_DIV);
    assign in_ready  = (state != S_DIV) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign div_go    = accept && (sel == OP_DIV) && (op_b != '0);

    alu_div_seq #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_go),
        .dividend (op_a),
        .divisor  (op_b),
        .done     (div_done),
        .quotient (div_q)
    );

    // Stage p0: single-cycle operation and flag evaluation
    always_comb begin
        sum      = {1'b0, op_a} + {1'b0, op_b};
        dif      = {1'b0, op_a} - {1'b0, op_b};
        prod     = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
        shl_full = {{WIDTH{1'b0}}, op_a} << op_b;
        shr_full = {op_a, {WIDTH{1'b0}}} >> op_b;
        sh_big   = ({1'b0, op_b} >= (WIDTH+1)'(WIDTH));
        res_p0   = '0;
        flg_p0   = '0;
        case (sel)
            OP_ADD: begin
                flg_p0[FLG_CARRY] = sum[WIDTH];
                res_p0 = sat_hi(sum[WIDTH-1:0], sum[WIDTH]);
            end
            OP_SUB: begin
                flg_p0[FLG_BORROW] = dif[WIDTH];
                res_p0 = sat_lo(dif[WIDTH-1:0], dif[WIDTH]);
            end
            OP_MUL: begin
                flg_p0[FLG_MOVF] = (prod[2*WIDTH-1:WIDTH] != '0);
                res_p0 = sat_hi(prod[WIDTH-1:0], flg_p0[FLG_MOVF]);
            end
            OP_DIV: begin
                res_p0 = '1;
                flg_p0[FLG_INV] = (op_b == '0);
            end
            OP_SHL: begin
                res_p0 = sh_big ? '0 : shl_full[WIDTH-1:0];
                flg_p0[FLG_CARRY] = sh_big ? (op_a != '0) : (shl_full[2*WIDTH-1:WIDTH] != '0);
            end
            OP_SHR: begin
                res_p0 = sh_big ? '0 : shr_full[2*WIDTH-1:WIDTH];
                flg_p0[FLG_BORROW] = sh_big ? (op_a != '0) : (shr_full[WIDTH-1:0] != '0);
            end
            OP_AND:  res_p0 = op_a & op_b;
            OP_OR:   res_p0 = op_a | op_b;
            OP_XOR:  res_p0 = op_a ^ op_b;
            OP_XNOR: res_p0 = ~(op_a ^ op_b);
            OP_NAND: res_p0 = ~(op_a & op_b);
            OP_NOR:  res_p0 = ~(op_a | op_b);
            default: flg_p0[FLG_INV] = 1'b1;
        endcase
        if (sel <= OP_NOR)
            flg_p0[FLG_ZERO] = (res_p0 == '0);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_OUT: begin
                if (accept)
                    state_nx = div_go ? S_DIV : S_OUT;
                else if ((state == S_OUT) && out_ready)
                    state_nx = S_IDLE;
            end
            S_DIV:   if (div_done) state_nx = S_OUT;
            default: state_nx = S_IDLE;
        endcase
    end

    // Stage p1: output register, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            result <= '0;
            flags  <= '0;
        end else begin
            state <= state_nx;
            if (accept && !div_go) begin
                result <= res_p0;
                flags  <= flg_p0;
            end else if (div_done) begin
                result <= div_q;
                flags  <= {4'b0000, (div_q == '0)};
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomized and directed bench for alu_seq_core against an arithmetic reference model.
module tb_alu_seq_core;

    localparam int W = 8;
`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [4:0]   flags;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode definitions.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input int s,
                                  output logic [63:0] r, output logic [4:0] f, output int lat);
        logic [63:0] m;
        logic [63:0] full;
        m   = (64'd1 << W) - 64'd1;
        r   = 0;
        f   = 5'b0;
        lat = 1;
        case (s)
            0: begin
                full = a + b;
                f[1] = (full > m);
                r = (f[1] && SAT) ? m : (full & m);
            end
            1: begin
                f[3] = (a < b);
                r = (f[3] && SAT) ? 64'd0 : ((a - b) & m);
            end
            2: begin
                full = a * b;
                f[2] = (full > m);
                r = (f[2] && SAT) ? m : (full & m);
            end
            3: begin
                if (b == 0) begin
                    r = m;
                    f[4] = 1'b1;
                end else begin
                    r = a / b;
                    lat = W + 1;
                end
            end
            4: begin
                if (b >= W) begin
                    r = 0;
                    f[1] = (a != 0);
                end else begin
                    full = a << b;
                    r = full & m;
                    f[1] = ((full >> W) != 0);
                end
            end
            5: begin
                if (b >= W) begin
                    r = 0;
                    f[3] = (a != 0);
                end else begin
                    r = a >> b;
                    f[3] = ((a & ((64'd1 << b) - 64'd1)) != 0);
                end
            end
            6:  r = a & b;
            7:  r = a | b;
            8:  r = a ^ b;
            9:  r = ~(a ^ b) & m;
            10: r = ~(a & b) & m;
            11: r = ~(a | b) & m;
            default: f[4] = 1'b1;
        endcase
        if (s < 12)
            f[0] = (r == 0);
    endfunction

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int s, input int hold);
        logic [63:0] er;
        logic [4:0]  ef;
        int          el;
        int          lat;
        int          bsy;
        model(a, b, s, er, ef, el);
        @(negedge clk);
        op_a     = W'(a);
        op_b     = W'(b);
        sel      = 4'(s);
        in_valid = 1'b1;
        check("in_ready_at_issue", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        bsy = 0;
        while (!out_valid && lat < 200) begin
            if (busy) bsy++;
            if (lat == 1) check("in_ready_during_div", in_ready, 0);
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency_op%0d", s), lat, el);
        check($sformatf("result_op%0d_%0h_%0h", s, a, b), result, er);
        check($sformatf("flags_op%0d_%0h_%0h", s, a, b), flags, ef);
        if (el > 1) check("busy_cycles", bsy, W);
        if (hold > 0) begin
            out_ready = 1'b0;
            repeat (hold) begin
                @(posedge clk);
                #1;
                check("hold_valid", out_valid, 1);
                check("hold_result", result, er);
                check("hold_flags", flags, ef);
                check("hold_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
        end
    endtask

    initial begin
        logic [63:0] m;
        logic [63:0] er;
        logic [4:0]  ef;
        int          el;
        m         = (64'd1 << W) - 64'd1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        sel       = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        run_op(64'hF0, 64'h20, 0, 0);
        run_op(64'h05, 64'h07, 1, 0);
        run_op(200, 7, 3, 0);
        run_op(9, 0, 3, 0);
        run_op(64'h10, 64'h10, 2, 5);

        // Back-to-back AND then OR with no bubble.
        @(negedge clk);
        op_a = W'(64'hC3); op_b = W'(64'h5A); sel = 4'h6; in_valid = 1'b1;
        check("b2b_ready_and", in_ready, 1);
        @(posedge clk);
        #1;
        model(64'hC3, 64'h5A, 6, er, ef, el);
        check("b2b_and_result", result, er);
        check("b2b_and_flags", flags, ef);
        @(negedge clk);
        sel = 4'h7;
        check("b2b_ready_or", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model(64'hC3, 64'h5A, 7, er, ef, el);
        check("b2b_or_result", result, er);
        check("b2b_or_valid", out_valid, 1);

        run_op(64'h81, 1, 4, 0);
        run_op(64'h03, 9, 5, 0);
        run_op(64'h55, 64'h0F, 13, 0);
        run_op(m, 1, 0, 0);
        run_op(0, 0, 6, 0);

        // Reset mid-divide.
        @(negedge clk);
        op_a = W'(200); op_b = W'(7); sel = 4'h3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(200, 7, 3, 0);
        run_op(m, 1, 3, 0);
        run_op(5, m, 3, 0);

        for (int i = 0; i < 80; i++) begin
            int          s;
            logic [63:0] a;
            logic [63:0] b;
            s = $urandom_range(0, 15);
            a = {32'($urandom), 32'($urandom)} & m;
            b = {32'($urandom), 32'($urandom)} & m;
            if ((s == 4 || s == 5) && ($urandom_range(0, 3) != 0))
                b = 64'($urandom_range(0, W + 2));
            if (s == 3 && $urandom_range(0, 7) == 0)
                b = 0;
            run_op(a, b, s, $urandom_range(0, 2));
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
